// File: rtl/renode_inputs_monitor.sv
// Input-change monitor: samples a bank of synchronous input lines, remembers
// which lines changed in a sticky pending vector, and reports them one at a
// time (lowest index first) through a valid/ready event channel.
module renode_inputs_monitor #(
  parameter int INPUTS_COUNT = 1,
  localparam int IDX_W = (INPUTS_COUNT > 1) ? $clog2(INPUTS_COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [INPUTS_COUNT-1:0] inputs,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [IDX_W-1:0]        evt_index,
  output logic                    evt_value,
  output logic [INPUTS_COUNT-1:0] sampled,
  output logic [INPUTS_COUNT-1:0] pending
);

  // Registered copy of the lines and the sticky change flags.
  logic [INPUTS_COUNT-1:0] sampled_q;
  logic [INPUTS_COUNT-1:0] pending_q;
  logic [INPUTS_COUNT-1:0] pending_d;

  // Set once the first post-reset edge has captured the baseline; until then
  // a difference between inputs and sampled is not a real change.
  logic                    base_q;

  // Event output register.
  logic                    evt_valid_q;
  logic                    evt_valid_d;
  logic [IDX_W-1:0]        evt_index_q;
  logic [IDX_W-1:0]        evt_index_d;
  logic                    evt_value_q;
  logic                    evt_value_d;

  // Combinational helpers.
  logic [INPUTS_COUNT-1:0] change;
  logic [INPUTS_COUNT-1:0] sel_onehot;
  logic [INPUTS_COUNT-1:0] clr_mask;
  logic [IDX_W-1:0]        sel_idx;
  logic                    sel_value;
  logic                    any_pending;
  logic                    load_en;
  logic                    take;

  // Lowest-index pending line as a one-hot vector: a bit is selected when it
  // is pending and no lower-numbered bit is pending.
  genvar gi;
  generate
    for (gi = 0; gi < INPUTS_COUNT; gi++) begin : g_sel
      if (gi == 0) begin : g_first
        assign sel_onehot[gi] = pending_q[gi];
      end else begin : g_rest
        assign sel_onehot[gi] = pending_q[gi] & ~(|pending_q[gi-1:0]);
      end
    end
  endgenerate

  // Detect changes against the previous sample and encode the selected line.
  always_comb begin
    change      = base_q ? (inputs ^ sampled_q) : '0;
    any_pending = |pending_q;
    sel_value   = |(sampled_q & sel_onehot);
    sel_idx     = '0;
    for (int i = 0; i < INPUTS_COUNT; i++) begin
      if (sel_onehot[i]) begin
        sel_idx = sel_idx | IDX_W'(i);
      end
    end
  end

  // Next-state for the event register and pending vector. The output
  // register reloads whenever it is empty or its event is being accepted;
  // selection only considers bits already pending, and a change landing on
  // the bit being cleared keeps it set.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_index_d = evt_index_q;
    evt_value_d = evt_value_q;
    load_en     = ~evt_valid_q | evt_ready;
    take        = load_en & any_pending;
    if (load_en) begin
      evt_valid_d = any_pending;
      if (any_pending) begin
        evt_index_d = sel_idx;
        evt_value_d = sel_value;
      end
    end
    clr_mask  = take ? sel_onehot : '0;
    pending_d = (pending_q & ~clr_mask) | change;
  end

  // State registers; reset clears everything, including any held event.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sampled_q   <= '0;
      pending_q   <= '0;
      base_q      <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_index_q <= '0;
      evt_value_q <= 1'b0;
    end else begin
      sampled_q   <= inputs;
      pending_q   <= pending_d;
      base_q      <= 1'b1;
      evt_valid_q <= evt_valid_d;
      evt_index_q <= evt_index_d;
      evt_value_q <= evt_value_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_index = evt_index_q;
  assign evt_value = evt_value_q;
  assign sampled   = sampled_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_renode_inputs_monitor.sv
// Directed bench for renode_inputs_monitor with four input lines.
module tb_renode_inputs_monitor;

  logic       clk;
  logic       resetn;
  logic [3:0] inputs;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_index;
  logic       evt_value;
  logic [3:0] sampled;
  logic [3:0] pending;
  logic [7:0] obs;

  int total = 0;
  int bad   = 0;

  renode_inputs_monitor #(.INPUTS_COUNT(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .inputs    (inputs),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_index (evt_index),
    .evt_value (evt_value),
    .sampled   (sampled),
    .pending   (pending)
  );

  assign obs = {evt_valid, evt_index, evt_value, pending};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected-vector builder: {valid, index, value, pending}.
  function automatic logic [7:0] ev(logic v, logic [1:0] i, logic val, logic [3:0] p);
    return {v, i, val, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with the given inputs, release mid-cycle, then let the baseline edge pass.
  task automatic do_reset(input logic [3:0] val, input logic rdy);
    resetn    = 1'b0;
    inputs    = val;
    evt_ready = rdy;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    resetn    = 1'b1;
    inputs    = 4'b1010;
    evt_ready = 1'b1;
    #3;
    resetn = 1'b0;
    #1;
    total++;
    if ({obs, sampled} !== 12'h000) begin
      bad++;
      $display("FAIL reset_async: got obs=%b sampled=%b want all zero", obs, sampled);
    end
    tick();
    total++;
    if ({obs, sampled} !== 12'h000) begin
      bad++;
      $display("FAIL reset_held: got obs=%b sampled=%b want all zero", obs, sampled);
    end
    resetn = 1'b1;
    tick();
    total++;
    if ({evt_valid, pending, sampled} !== {1'b0, 4'b0000, 4'b1010}) begin
      bad++;
      $display("FAIL reset_baseline: got v=%b pend=%b sampled=%b want v=0 pend=0000 sampled=1010",
               evt_valid, pending, sampled);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if ({evt_valid, pending} !== 5'b0) begin
        bad++;
        $display("FAIL reset_quiet cycle %0d: got v=%b pend=%b want v=0 pend=0000", k, evt_valid, pending);
      end
    end
    $display("test_reset: baseline 1010 captured, quiet for 10 cycles");
  endtask

  // Shared table runner body is inlined per task so each scenario reads on its own.
  task automatic test_single();
    logic [3:0] in_t [0:2];
    logic       rd_t [0:2];
    logic [7:0] ex_t [0:2];
    in_t = '{4'b0001, 4'b0001, 4'b0001};
    rd_t = '{1'b1, 1'b1, 1'b1};
    ex_t = '{ev(0,0,0,4'b0001), ev(1,0,1,4'b0000), ev(0,0,0,4'b0000)};
    do_reset(4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      inputs = in_t[k]; evt_ready = rd_t[k];
      tick();
      total++;
      if (ex_t[k][7] ? (obs !== ex_t[k]) : ({evt_valid, pending} !== {ex_t[k][7], ex_t[k][3:0]})) begin
        bad++;
        $display("FAIL single step %0d: got %b want %b", k, obs, ex_t[k]);
      end
      $display("single step %0d: v=%b idx=%0d val=%b pend=%b", k, evt_valid, evt_index, evt_value, pending);
      if (k == 0) begin
        total++;
        if (sampled !== 4'b0001) begin
          bad++;
          $display("FAIL single_sampled: got %b want 0001", sampled);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] in_t [0:3];
    logic       rd_t [0:3];
    logic [7:0] ex_t [0:3];
    in_t = '{4'b1001, 4'b1001, 4'b1001, 4'b1001};
    rd_t = '{1'b1, 1'b1, 1'b1, 1'b1};
    ex_t = '{ev(0,0,0,4'b1001), ev(1,0,1,4'b1000), ev(1,3,1,4'b0000), ev(0,0,0,4'b0000)};
    do_reset(4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      inputs = in_t[k]; evt_ready = rd_t[k];
      tick();
      total++;
      if (ex_t[k][7] ? (obs !== ex_t[k]) : ({evt_valid, pending} !== {ex_t[k][7], ex_t[k][3:0]})) begin
        bad++;
        $display("FAIL simultaneous step %0d: got %b want %b", k, obs, ex_t[k]);
      end
      $display("simultaneous step %0d: v=%b idx=%0d val=%b pend=%b", k, evt_valid, evt_index, evt_value, pending);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] in_t [0:5];
    logic       rd_t [0:5];
    logic [7:0] ex_t [0:5];
    in_t = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    rd_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ex_t = '{ev(0,0,0,4'b1111), ev(1,0,1,4'b1110), ev(1,1,1,4'b1100),
             ev(1,2,1,4'b1000), ev(1,3,1,4'b0000), ev(0,0,0,4'b0000)};
    do_reset(4'b0000, 1'b1);
    for (int k = 0; k < 6; k++) begin
      inputs = in_t[k]; evt_ready = rd_t[k];
      tick();
      total++;
      if (ex_t[k][7] ? (obs !== ex_t[k]) : ({evt_valid, pending} !== {ex_t[k][7], ex_t[k][3:0]})) begin
        bad++;
        $display("FAIL back_to_back step %0d: got %b want %b", k, obs, ex_t[k]);
      end
      $display("back_to_back step %0d: v=%b idx=%0d val=%b pend=%b", k, evt_valid, evt_index, evt_value, pending);
    end
  endtask

  // Line 0 event is stalled while line 2 toggles 0->1->0->1: line 2 stays
  // pending once and is reported once with value 1, held until accepted.
  task automatic test_sticky();
    logic [3:0] in_t [0:14];
    logic       rd_t [0:14];
    logic [7:0] ex_t [0:14];
    in_t = '{4'b0001, 4'b0001, 4'b0101, 4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
             4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
    rd_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ex_t = '{ev(0,0,0,4'b0001), ev(1,0,1,4'b0000), ev(1,0,1,4'b0100), ev(1,0,1,4'b0100),
             ev(1,0,1,4'b0100), ev(1,2,1,4'b0000), ev(1,2,1,4'b0000), ev(1,2,1,4'b0000),
             ev(1,2,1,4'b0000), ev(0,0,0,4'b0000), ev(0,0,0,4'b0000), ev(0,0,0,4'b0000),
             ev(0,0,0,4'b0000), ev(0,0,0,4'b0000), ev(0,0,0,4'b0000)};
    do_reset(4'b0000, 1'b0);
    for (int k = 0; k < 15; k++) begin
      inputs = in_t[k]; evt_ready = rd_t[k];
      tick();
      total++;
      if (ex_t[k][7] ? (obs !== ex_t[k]) : ({evt_valid, pending} !== {ex_t[k][7], ex_t[k][3:0]})) begin
        bad++;
        $display("FAIL sticky step %0d: got %b want %b", k, obs, ex_t[k]);
      end
      $display("sticky step %0d: v=%b idx=%0d val=%b pend=%b", k, evt_valid, evt_index, evt_value, pending);
    end
  endtask

  // Line 1 rises, then falls while its event is stalled: a second event with value 0.
  task automatic test_repend();
    logic [3:0] in_t [0:6];
    logic       rd_t [0:6];
    logic [7:0] ex_t [0:6];
    in_t = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    rd_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ex_t = '{ev(0,0,0,4'b0010), ev(1,1,1,4'b0000), ev(1,1,1,4'b0010), ev(1,1,1,4'b0010),
             ev(1,1,0,4'b0000), ev(0,0,0,4'b0000), ev(0,0,0,4'b0000)};
    do_reset(4'b0000, 1'b0);
    for (int k = 0; k < 7; k++) begin
      inputs = in_t[k]; evt_ready = rd_t[k];
      tick();
      total++;
      if (ex_t[k][7] ? (obs !== ex_t[k]) : ({evt_valid, pending} !== {ex_t[k][7], ex_t[k][3:0]})) begin
        bad++;
        $display("FAIL repend step %0d: got %b want %b", k, obs, ex_t[k]);
      end
      $display("repend step %0d: v=%b idx=%0d val=%b pend=%b", k, evt_valid, evt_index, evt_value, pending);
    end
  endtask

  // A change on the bit being selected at the same edge keeps it pending.
  task automatic test_set_wins();
    logic [3:0] in_t [0:3];
    logic       rd_t [0:3];
    logic [7:0] ex_t [0:3];
    in_t = '{4'b0100, 4'b0000, 4'b0000, 4'b0000};
    rd_t = '{1'b1, 1'b1, 1'b1, 1'b1};
    ex_t = '{ev(0,0,0,4'b0100), ev(1,2,1,4'b0100), ev(1,2,0,4'b0000), ev(0,0,0,4'b0000)};
    do_reset(4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      inputs = in_t[k]; evt_ready = rd_t[k];
      tick();
      total++;
      if (ex_t[k][7] ? (obs !== ex_t[k]) : ({evt_valid, pending} !== {ex_t[k][7], ex_t[k][3:0]})) begin
        bad++;
        $display("FAIL set_wins step %0d: got %b want %b", k, obs, ex_t[k]);
      end
      $display("set_wins step %0d: v=%b idx=%0d val=%b pend=%b", k, evt_valid, evt_index, evt_value, pending);
    end
  endtask

  // Line 1 pulses high and back while line 0's event is stalled: reported once, value 0.
  task automatic test_toggle_return();
    logic [3:0] in_t [0:5];
    logic       rd_t [0:5];
    logic [7:0] ex_t [0:5];
    in_t = '{4'b0001, 4'b0011, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    rd_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ex_t = '{ev(0,0,0,4'b0001), ev(1,0,1,4'b0010), ev(1,0,1,4'b0010),
             ev(1,1,0,4'b0000), ev(0,0,0,4'b0000), ev(0,0,0,4'b0000)};
    do_reset(4'b0000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      inputs = in_t[k]; evt_ready = rd_t[k];
      tick();
      total++;
      if (ex_t[k][7] ? (obs !== ex_t[k]) : ({evt_valid, pending} !== {ex_t[k][7], ex_t[k][3:0]})) begin
        bad++;
        $display("FAIL toggle_return step %0d: got %b want %b", k, obs, ex_t[k]);
      end
      $display("toggle_return step %0d: v=%b idx=%0d val=%b pend=%b", k, evt_valid, evt_index, evt_value, pending);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(4'b0000, 1'b0);
    inputs = 4'b0111;
    tick();
    tick();
    total++;
    if (obs !== ev(1,0,1,4'b0110)) begin
      bad++;
      $display("FAIL reset_mid_setup: got %b want %b", obs, ev(1,0,1,4'b0110));
    end
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if ({obs, sampled} !== 12'h000) begin
      bad++;
      $display("FAIL reset_mid_async: got obs=%b sampled=%b want all zero", obs, sampled);
    end
    tick();
    resetn    = 1'b1;
    evt_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if ({evt_valid, pending, sampled} !== {1'b0, 4'b0000, 4'b0111}) begin
        bad++;
        $display("FAIL reset_mid_quiet cycle %0d: got v=%b pend=%b sampled=%b want v=0 pend=0000 sampled=0111",
                 k, evt_valid, pending, sampled);
      end
    end
    $display("test_reset_mid: held event and pending changes discarded");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b1;
    inputs    = 4'b0000;
    evt_ready = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_sticky();
    test_repend();
    test_set_wins();
    test_toggle_return();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
